rot_arbiter: RTL

Round-robin arbiter and sequencer that shares one N-bit barrel rotator (right rotate by k, N = 2^LOG2_N) among NUM_REQ requesters. Each requester offers an operand and rotate amount on a valid/ready handshake. One grant is issued per cycle, the rotation is computed through the shared rot datapath, and the result is returned in a single registered output slot tagged with the requester ID. It sits between the requesting engines and the rotator, so no client needs its own copy of the log2(N)-stage mux network.

---
 rtl/rot_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one log2(N)-stage barrel rotator among NUM_REQ requesters.
// Results land in a single registered slot tagged with the winning requester ID.
module rot_arbiter #(
  parameter int N       = 1024,
  parameter int LOG2_N  = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [0:NUM_REQ*N-1]        req_bits,
  input  logic [0:NUM_REQ*LOG2_N-1]   req_k,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [0:N-1]                resp_bits,
  output logic [ID_W-1:0]             resp_id,
  output logic [15:0]                 op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a port in any cycle where its valid and
  // ready are both high at the rising edge; valid never waits on ready.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

  slot_state_t         state_q, state_d;
  logic [ID_W-1:0]     last_grant;
  logic [N-1:0]        resp_data;
  logic                found;
  logic [NUM_REQ-1:0]  winner_oh;
  logic [ID_W-1:0]     winner_id;
  logic                can_accept;
  logic                accept;
  logic                drain;
  logic [N-1:0]        sel_bits;
  logic [LOG2_N-1:0]   sel_k;
  logic [N-1:0]        rot_result;

  // Search starts one past the last grant and wraps; first valid wins.
  always_comb begin
    found     = 1'b0;
    winner_oh = '0;
    winner_id = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int cand;
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[IDX_W'(cand)]) begin
        found                   = 1'b1;
        winner_oh[IDX_W'(cand)] = 1'b1;
        winner_id               = ID_W'(cand);
      end
    end
  end

  assign can_accept = (state_q == S_EMPTY) || resp_ready;
  assign req_ready  = (rst_n && can_accept) ? winner_oh : '0;
  assign accept     = |(req_valid & req_ready);
  assign drain      = (state_q == S_FULL) && resp_ready;
  assign resp_valid = (state_q == S_FULL);
  assign resp_bits  = resp_data;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_FULL;
    end else if (drain) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sel_bits = '0;
    sel_k    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (winner_oh[r]) begin
        sel_bits = req_bits[r*N +: N];
        sel_k    = req_k[r*LOG2_N +: LOG2_N];
      end
    end
  end

  // Stage s rotates right by 2^s when bit s of the amount is set.
  for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
    logic [N-1:0] din;
    logic [N-1:0] dout;
    if (s == 0) begin : g_first
      assign din = sel_bits;
    end else begin : g_next
      assign din = g_stage[s-1].dout;
    end
    assign dout = sel_k[s] ? {din[(1<<s)-1:0], din[N-1:(1<<s)]} : din;
  end

  assign rot_result = g_stage[LOG2_N-1].dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_count   <= '0;
    end else begin
      if (accept) begin
        resp_data  <= rot_result;
        resp_id    <= winner_id;
        last_grant <= winner_id;
      end
      if (drain) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule
